// File: rtl/dsd_lsu.sv
// dsd_lsu: queued load/store unit driving a req/ack data-memory port.
// Optional ack timeout with sticky error: define DSD_LSU_TIMEOUT_EN.
module dsd_lsu #(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int RW     = 3,
  parameter int QDEPTH = 2,
  parameter int TO_CYC = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_store,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_data,
  input  logic [RW-1:0] ex_rd,
  output logic          dmem_req,
  output logic          dmem_wr,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_data_out,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_data_in,
  output logic          wb_wen,
  output logic [RW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          busy,
  output logic          err_timeout
);

  localparam int PW = $clog2(QDEPTH);

  typedef struct packed {
    logic          st;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WB
  } state_t;

  op_t           q [QDEPTH];
  op_t           cur;
  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          to_lim;
  logic [DW-1:0] rdata;
  logic          err_q;
  state_t        state_q;
  state_t        state_d;

  assign full  = (wptr ^ rptr) == {1'b1, {PW{1'b0}}};
  assign empty = wptr == rptr;
  assign push  = ex_valid & ~full;
  assign pop   = (state_q == IDLE) & ~empty;

`ifdef DSD_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC);
  logic [CW-1:0] to_cnt;

  assign to_lim = to_cnt == CW'(TO_CYC - 1);

  // Count REQ cycles without ack; cleared whenever not in REQ
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      to_cnt <= '0;
    else if (state_q != REQ)
      to_cnt <= '0;
    else if (!dmem_ack)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_to;

  assign to_lim    = 1'b0;
  assign unused_to = TO_CYC != 0;
`endif

  // Queue storage, written at the tail on push
  always_ff @(posedge clk) begin
    if (push)
      q[wptr[PW-1:0]] <= '{ex_store, ex_addr, ex_data, ex_rd};
  end

  // Queue pointers with wrap bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  // Stage state, request registers, load data and sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cur     <= '0;
      rdata   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop)
        cur <= q[rptr[PW-1:0]];
      if (state_q == REQ && !cur.st) begin
        if (dmem_ack)
          rdata <= dmem_data_in;
        else if (to_lim)
          rdata <= '0;
      end
      if (state_q == REQ && !dmem_ack && to_lim)
        err_q <= 1'b1;
    end
  end

  // Next-state: ack wins over the timeout limit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!empty) state_d = REQ;
      REQ: begin
        if (dmem_ack || to_lim)
          state_d = cur.st ? IDLE : WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ex_ready      = ~full;
  assign dmem_req      = state_q == REQ;
  assign dmem_wr       = dmem_req & cur.st;
  assign dmem_addr     = cur.a;
  assign dmem_data_out = cur.d;
  assign wb_wen        = state_q == WB;
  assign wb_addr       = cur.rd;
  assign wb_data       = rdata;
  assign busy          = ~empty | (state_q != IDLE);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_dsd_lsu.sv
// tb_dsd_lsu: scoreboard bench for dsd_lsu.
// Memory responder plus in-order reference memory model.
module tb_dsd_lsu;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_ready, ex_store;
  logic [15:0] ex_addr;
  logic [31:0] ex_data;
  logic [2:0]  ex_rd;
  logic        dmem_req, dmem_wr, dmem_ack;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_data_out, dmem_data_in;
  logic        wb_wen;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy, err_timeout;

  dsd_lsu #(.DW(32), .AW(16), .RW(3), .QDEPTH(2), .TO_CYC(TO)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_store(ex_store),
    .ex_addr(ex_addr), .ex_data(ex_data), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_data_out(dmem_data_out), .dmem_ack(dmem_ack),
    .dmem_data_in(dmem_data_in),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [15:0] a;
    logic [31:0] d;
  } rq_t;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] d;
  } wb_t;

  rq_t         req_q[$];
  wb_t         wb_q[$];
  logic [31:0] mem [logic [15:0]];
  logic [31:0] mdl [logic [15:0]];

  int nchk = 0;
  int nerr = 0;
  int fixed_lat = 0;
  bit hold_ack = 0;
  bit spur = 0;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endfunction

  function automatic logic [31:0] dflt(logic [15:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [31:0] mem_rd(logic [15:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mdl_rd(logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : dflt(a);
  endfunction

  // Memory responder: acks after a per-request latency
  initial begin
    int waited;
    int cur_lat;
    waited = 0;
    cur_lat = 0;
    dmem_ack = 1'b0;
    dmem_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req && !hold_ack) begin
        if (waited == 0)
          cur_lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
        if (waited == cur_lat) begin
          dmem_ack = 1'b1;
          dmem_data_in = dmem_wr ? $urandom : mem_rd(dmem_addr);
          if (dmem_wr)
            mem[dmem_addr] = dmem_data_out;
          waited = 0;
        end else begin
          dmem_ack = 1'b0;
          waited++;
        end
      end else begin
        dmem_ack = spur;
        waited = 0;
      end
    end
  end

  // Monitor: request stability, request order, writeback results
  logic        p_req, p_ack, p_wr, p_wen;
  logic [15:0] p_addr;
  logic [31:0] p_data;

  always @(negedge clk) begin
    if (!resetn) begin
      p_req = 0;
      p_ack = 0;
      p_wen = 0;
    end else begin
      if (dmem_req && p_req && !p_ack) begin
        chk("req_hold_wr", dmem_wr, p_wr);
        chk("req_hold_addr", dmem_addr, p_addr);
        chk("req_hold_data", dmem_data_out, p_data);
      end
      if (dmem_req && dmem_ack) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          rq_t r;
          r = req_q.pop_front();
          chk("req_wr", dmem_wr, r.st);
          chk("req_addr", dmem_addr, r.a);
          if (r.st)
            chk("req_data", dmem_data_out, r.d);
        end
      end
      if (wb_wen) begin
        chk("wb_pulse", p_wen, 0);
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_addr", wb_addr, w.rd);
          chk("wb_data", wb_data, w.d);
        end
      end
      p_req = dmem_req;
      p_ack = dmem_ack;
      p_wr = dmem_wr;
      p_wen = wb_wen;
      p_addr = dmem_addr;
      p_data = dmem_data_out;
    end
  end

  // Issue one op; the model records it at the accepting edge
  task automatic push_op(input bit st, input logic [15:0] a,
                         input logic [31:0] d, input logic [2:0] rd,
                         input bit to, input bit rec);
    int n = 0;
    ex_valid = 1;
    ex_store = st;
    ex_addr = a;
    ex_data = d;
    ex_rd = rd;
    while (!ex_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) begin
      chk("push_stuck", 0, 1);
      ex_valid = 0;
      return;
    end
    @(posedge clk);
    if (rec) begin
      if (st) begin
        mdl[a] = d;
        if (!to) req_q.push_back('{1, a, d});
      end else begin
        if (!to) req_q.push_back('{0, a, 0});
        wb_q.push_back('{rd, to ? 32'h0 : mdl_rd(a)});
      end
    end
    #1;
    ex_valid = 0;
  endtask

  task automatic drain(input string n);
    int c = 0;
    while ((busy || req_q.size() != 0 || wb_q.size() != 0) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk(n, busy || req_q.size() != 0 || wb_q.size() != 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 resetn = 0;
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_wen", wb_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ex_ready, 1);
    chk("rst_err", err_timeout, 0);
    @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("rel_req", dmem_req, 0);
    chk("rel_busy", busy, 0);
    chk("rel_ready", ex_ready, 1);
  endtask

  initial begin
    int n;
    resetn = 0;
    ex_valid = 0;
    ex_store = 0;
    ex_addr = '0;
    ex_data = '0;
    ex_rd = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("init_ready", ex_ready, 1);
    chk("init_req", dmem_req, 0);
    chk("init_wr", dmem_wr, 0);
    chk("init_addr", dmem_addr, 0);
    chk("init_wen", wb_wen, 0);
    chk("init_wbdata", wb_data, 0);
    chk("init_busy", busy, 0);
    chk("init_err", err_timeout, 0);

    // Reset while a request is outstanding
    hold_ack = 1;
    @(posedge clk);
    #1;
    push_op(1, 16'h0040, 32'hA5A5A5A5, 0, 0, 0);
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_req_up", dmem_req, 1);
    do_reset();
    hold_ack = 0;

    // Zero-wait load: exact latency
    mem[16'h0010] = 32'hDEADBEEF;
    mdl[16'h0010] = 32'hDEADBEEF;
    fixed_lat = 0;
    push_op(0, 16'h0010, 0, 3, 0, 1);
    @(negedge clk);
    chk("t2_req_T", dmem_req, 0);
    @(negedge clk);
    chk("t2_req_T1", dmem_req, 1);
    chk("t2_wen_T1", wb_wen, 0);
    @(negedge clk);
    chk("t2_wen_T2", wb_wen, 1);
    chk("t2_wbaddr", wb_addr, 3);
    chk("t2_wbdata", wb_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_wen_T3", wb_wen, 0);
    chk("t2_busy", busy, 0);

    // Store with five wait cycles
    fixed_lat = 5;
    push_op(1, 16'h0020, 32'h12345678, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_req) n++;
      if (!busy) break;
    end
    chk("t3_req_cycles", n, 6);
    chk("t3_busy", busy, 0);

    // Back-pressure with ack held low
    hold_ack = 1;
    fixed_lat = 0;
    push_op(0, 16'h0001, 0, 1, 0, 1);
    push_op(1, 16'h0002, 32'hCAFEF00D, 0, 0, 1);
    push_op(0, 16'h0002, 0, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_full", ex_ready, 0);
      chk("t4_head", dmem_addr, 16'h0001);
    end
    hold_ack = 0;
    push_op(1, 16'h0003, 32'h0BADBEEF, 0, 0, 1);
    drain("t4_drain");

    // Push in the ack cycle
    fixed_lat = 2;
    push_op(0, 16'h0005, 0, 4, 0, 1);
    n = 0;
    while (!(dmem_req && dmem_ack) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_ack_seen", dmem_ack, 1);
    push_op(1, 16'h0006, 32'h55AA33CC, 0, 0, 1);
    drain("t5_drain");

    // Spurious ack while idle
    @(posedge clk);
    #1 spur = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_spur_req", dmem_req, 0);
      chk("t5_spur_wen", wb_wen, 0);
      chk("t5_spur_busy", busy, 0);
    end
    spur = 0;
    repeat (2) @(posedge clk);
    #1;

    // Random traffic against the reference memory
    fixed_lat = -1;
    for (int i = 0; i < 60; i++) begin
      push_op(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
              $urandom, 3'($urandom_range(0, 7)), 0, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain("rand_drain");

`ifdef DSD_LSU_TIMEOUT_EN
    // Load with no ack times out
    hold_ack = 1;
    @(posedge clk);
    #1;
    push_op(0, 16'h0007, 0, 5, 1, 1);
    drain("t6_to_drain");
    chk("t6_err_set", err_timeout, 1);
    hold_ack = 0;
    do_reset();
    // Ack on the limit cycle completes normally
    fixed_lat = TO - 1;
    push_op(0, 16'h0010, 0, 6, 0, 1);
    drain("t6_lim_drain");
    chk("t6_err_clear", err_timeout, 0);
`else
    chk("err_tied", err_timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
